// File: rtl/seg7_reader.sv
// seg7_reader: reads back an active-low multiplexed 7-segment bus and
// reconstructs the hex nibble currently shown on each digit.
//
// The {an,segs} bus is registered every cycle. A run-length counter measures
// how many consecutive edges the bus has stayed unchanged. Once the run reaches
// STABLE_CYCLES the FSM spends exactly one cycle in CAPTURE and decodes the
// registered sample. It then parks in HOLD until the bus changes again, so
// there is one capture per stable period.
module seg7_reader #(
    parameter int NUM_DIGITS    = 4,   // 1..8 multiplexed digits
    parameter int IDX_W         = 2,   // 2**IDX_W >= NUM_DIGITS
    parameter int STABLE_CYCLES = 4    // 2..255 identical samples before capture
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              segs,
    input  logic [NUM_DIGITS-1:0]   an,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    upd,
    output logic [IDX_W-1:0]        upd_idx,
    output logic                    err,
    output logic [1:0]              dbg_state
);

    localparam int         SMP_W   = NUM_DIGITS + 7;
    localparam logic [7:0] STAB_C  = 8'(STABLE_CYCLES);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_WAIT    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    state_t                  state_q;
    logic [SMP_W-1:0]        sample_q;
    logic [7:0]              cnt_q;
    logic [4*NUM_DIGITS-1:0] value_q;
    logic [NUM_DIGITS-1:0]   digit_valid_q;
    logic                    upd_q;
    logic                    err_q;
    logic [IDX_W-1:0]        upd_idx_q;

    logic [SMP_W-1:0]        in_d;
    logic                    changed;
    logic [7:0]              cnt_d;
    logic [NUM_DIGITS-1:0]   smp_an;
    logic [6:0]              smp_segs;
    logic [3:0]              low_cnt;
    logic [IDX_W-1:0]        sel_idx;
    logic                    dec_hit;
    logic [3:0]              dec_nib;
    logic                    smp_blank;

    assign value       = value_q;
    assign digit_valid = digit_valid_q;
    assign upd         = upd_q;
    assign err         = err_q;
    assign upd_idx     = upd_idx_q;
    assign dbg_state   = state_q;

    // Input comparison and saturating run-length counter.
    // The counter sits at 1 on the first edge of a new value, so reaching
    // STABLE_CYCLES means the value was seen on that many consecutive edges.
    always_comb begin
        in_d    = {an, segs};
        changed = (in_d != sample_q);
        if (changed) begin
            cnt_d = 8'd1;
        end else if (cnt_q >= STAB_C) begin
            cnt_d = STAB_C;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Analyse the registered sample: how many enables are low and which is
    // the lowest-numbered one. Scanning downward lets the lowest index win.
    always_comb begin
        smp_an   = sample_q[SMP_W-1:7];
        smp_segs = sample_q[6:0];
        low_cnt  = 4'd0;
        sel_idx  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (!smp_an[i]) begin
                low_cnt = low_cnt + 4'd1;
                sel_idx = IDX_W'(i);
            end
        end
    end

    // Inverse segment decode (gfedcba, active-low) back to a hex nibble.
    // The blank pattern is kept apart from the table so that it clears the
    // valid flag without being treated as an error.
    always_comb begin
        dec_hit   = 1'b1;
        dec_nib   = 4'h0;
        smp_blank = (smp_segs == SEG_BLANK);
        case (smp_segs)
            7'b1000000: dec_nib = 4'h0;
            7'b1111001: dec_nib = 4'h1;
            7'b0100100: dec_nib = 4'h2;
            7'b0110000: dec_nib = 4'h3;
            7'b0011001: dec_nib = 4'h4;
            7'b0010010: dec_nib = 4'h5;
            7'b0000010: dec_nib = 4'h6;
            7'b1111000: dec_nib = 4'h7;
            7'b0000000: dec_nib = 4'h8;
            7'b0010000: dec_nib = 4'h9;
            7'b0001000: dec_nib = 4'hA;
            7'b0000011: dec_nib = 4'hB;
            7'b1000110: dec_nib = 4'hC;
            7'b0100001: dec_nib = 4'hD;
            7'b0000110: dec_nib = 4'hE;
            7'b0001110: dec_nib = 4'hF;
            default:    dec_hit = 1'b0;
        endcase
    end

    // Sampling FSM with registered slot storage and result pulses.
    // A bus change always wins over a pending capture and restarts counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_WAIT;
            sample_q      <= '1;
            cnt_q         <= 8'd0;
            value_q       <= '0;
            digit_valid_q <= '0;
            upd_q         <= 1'b0;
            err_q         <= 1'b0;
            upd_idx_q     <= '0;
        end else begin
            sample_q <= in_d;
            cnt_q    <= cnt_d;
            upd_q    <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                ST_WAIT: begin
                    if (cnt_d == STAB_C) begin
                        state_q <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (changed) begin
                        state_q <= ST_WAIT;
                    end else begin
                        state_q <= ST_HOLD;
                        if (low_cnt > 4'd1) begin
                            // Several digits enabled at once: report, write nothing.
                            err_q     <= 1'b1;
                            upd_idx_q <= sel_idx;
                        end else if (low_cnt == 4'd1) begin
                            upd_idx_q <= sel_idx;
                            for (int i = 0; i < NUM_DIGITS; i++) begin
                                if (sel_idx == IDX_W'(i)) begin
                                    if (dec_hit) begin
                                        value_q[4*i +: 4] <= dec_nib;
                                        digit_valid_q[i]  <= 1'b1;
                                    end else begin
                                        // Blank or garbage: nibble kept, flag cleared.
                                        digit_valid_q[i]  <= 1'b0;
                                    end
                                end
                            end
                            if (dec_hit) begin
                                upd_q <= 1'b1;
                            end else if (!smp_blank) begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (changed) begin
                        state_q <= ST_WAIT;
                    end
                end
                default: begin
                    state_q <= ST_WAIT;
                end
            endcase
        end
    end

endmodule
